timer0_interrupt_controller: RTL and testbench

//   Sequences Timer0 interrupt requests to the CPU. Monitors TIFR/TIMSK from timer_8bit and the global I flag.

---
 rtl/timer0_interrupt_controller.sv | 115 +++++++++++
 tb/tb_timer0_interrupt_controller.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/timer0_interrupt_controller.sv
// rtl/timer0_interrupt_controller.sv - Timer0 interrupt sequencer: OCF0/TOV0 arbitration, CPU request, flag clear on ack
module timer0_interrupt_controller #(
    parameter int               VEC_W       = 16,
    parameter logic [VEC_W-1:0] COMP_VECTOR = 16'h0014,
    parameter logic [VEC_W-1:0] OVF_VECTOR  = 16'h0016
) (
    input  logic             sysClock,
    input  logic             rst_n,
    input  logic [7:0]       TIFR_in,
    input  logic [7:0]       TIMSK_in,
    input  logic             global_int_enable,
    input  logic             irq_ack,
    output logic             irq,
    output logic [VEC_W-1:0] irq_vector,
    output logic             TIFR_write_enable,
    output logic [7:0]       TIFR_write_data,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, REQ, CLEAR} state_t;
    typedef enum logic [1:0] {SRV_NONE, SRV_COMP, SRV_OVF} served_t;

    state_t           state_q, state_d;
    served_t          served_q, served_d;
    logic             irq_q, irq_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             we_q, we_d;
    logic             busy_q, busy_d;

    logic       cmp, ovf, served_term;
    logic [7:0] served_bits;
    logic       unused_mask_bits;

    assign cmp              = TIFR_in[1] & TIMSK_in[1];
    assign ovf              = TIFR_in[0] & TIMSK_in[0];
    assign served_term      = (served_q == SRV_COMP) ? cmp : ovf;
    assign unused_mask_bits = ^TIMSK_in[7:2];

    always_comb begin
        state_d  = state_q;
        served_d = served_q;
        irq_d    = irq_q;
        vec_d    = vec_q;
        we_d     = 1'b0;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (global_int_enable && (cmp || ovf)) begin
                    state_d = REQ;
                    irq_d   = 1'b1;
                    busy_d  = 1'b1;
                    if (cmp) begin
                        served_d = SRV_COMP;
                        vec_d    = COMP_VECTOR;
                    end else begin
                        served_d = SRV_OVF;
                        vec_d    = OVF_VECTOR;
                    end
                end
            end
            REQ: begin
                // Ack wins over a same-cycle withdrawal so an accepted request is always cleared.
                if (irq_ack) begin
                    state_d = CLEAR;
                    irq_d   = 1'b0;
                    we_d    = 1'b1;
                end else if (!global_int_enable || !served_term) begin
                    state_d  = IDLE;
                    irq_d    = 1'b0;
                    busy_d   = 1'b0;
                    served_d = SRV_NONE;
                end
            end
            CLEAR: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                served_d = SRV_NONE;
            end
            default: begin
                state_d  = IDLE;
                irq_d    = 1'b0;
                busy_d   = 1'b0;
                served_d = SRV_NONE;
            end
        endcase
    end

    always_ff @(posedge sysClock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            served_q <= SRV_NONE;
            irq_q    <= 1'b0;
            vec_q    <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            served_q <= served_d;
            irq_q    <= irq_d;
            vec_q    <= vec_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
        end
    end

    // Write data tracks live TIFR so any other pending flag is written back unchanged.
    assign served_bits = {6'b0, served_q == SRV_COMP, served_q == SRV_OVF};

    assign irq               = irq_q;
    assign irq_vector        = vec_q;
    assign TIFR_write_enable = we_q;
    assign TIFR_write_data   = we_q ? (TIFR_in & ~served_bits) : 8'h00;
    assign busy              = busy_q;

endmodule

// File: tb/tb_timer0_interrupt_controller.sv
// tb/tb_timer0_interrupt_controller.sv - Table-driven scoreboard bench for timer0_interrupt_controller
module tb_timer0_interrupt_controller;

    logic        sysClock = 1'b0;
    logic        rst_n;
    logic [7:0]  TIFR_in, TIMSK_in;
    logic        global_int_enable, irq_ack;
    logic        irq;
    logic [15:0] irq_vector;
    logic        TIFR_write_enable;
    logic [7:0]  TIFR_write_data;
    logic        busy;

    timer0_interrupt_controller dut (
        .sysClock(sysClock), .rst_n(rst_n), .TIFR_in(TIFR_in), .TIMSK_in(TIMSK_in),
        .global_int_enable(global_int_enable), .irq_ack(irq_ack), .irq(irq),
        .irq_vector(irq_vector), .TIFR_write_enable(TIFR_write_enable),
        .TIFR_write_data(TIFR_write_data), .busy(busy)
    );

    always #5 sysClock = ~sysClock;

    typedef struct packed {
        logic        irq;
        logic [15:0] vec;
        logic        we;
        logic [7:0]  data;
        logic        busy;
    } out_t;

    typedef struct {
        string      name;
        logic [7:0] tifr;
        logic [7:0] timsk;
        logic       gie;
        logic       ack;
        out_t       exp;
    } vec_t;

    vec_t tbl[$];
    out_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic out_t o(logic i, logic [15:0] v, logic w, logic [7:0] d, logic b);
        out_t r;
        r.irq = i; r.vec = v; r.we = w; r.data = d; r.busy = b;
        return r;
    endfunction

    function automatic void add(string n, logic [7:0] tf, logic [7:0] tm, logic g, logic a, out_t e);
        vec_t v;
        v.name = n; v.tifr = tf; v.timsk = tm; v.gie = g; v.ack = a; v.exp = e;
        tbl.push_back(v);
    endfunction

    function automatic out_t actual();
        return o(irq, irq_vector, TIFR_write_enable, TIFR_write_data, busy);
    endfunction

    // The vector is only meaningful while a request is presented, except where checked explicitly.
    task automatic check(string name, out_t e, logic vec_always);
        out_t a, m;
        a = actual();
        m = '1;
        if (!e.irq && !vec_always) m.vec = '0;
        n_assert++;
        if ((a & m) !== (e & m)) begin
            n_fail++;
            $display("FAIL %s: irq/vec/we/data/busy actual %0b/%h/%0b/%h/%0b required %0b/%h/%0b/%h/%0b",
                     name, a.irq, a.vec, a.we, a.data, a.busy, e.irq, e.vec, e.we, e.data, e.busy);
        end
    endtask

    task automatic step(vec_t v);
        @(negedge sysClock);
        TIFR_in = v.tifr; TIMSK_in = v.timsk; global_int_enable = v.gie; irq_ack = v.ack;
        exp_q.push_back(v.exp);
        @(posedge sysClock);
        #1;
        check(v.name, exp_q.pop_front(), 1'b0);
    endtask

    localparam logic [15:0] VC = 16'h0014;
    localparam logic [15:0] VO = 16'h0016;

    initial begin
        add("t1_idle",    8'h00, 8'h01, 1, 0, o(0, 0,  0, 8'h00, 0));
        add("t1_req",     8'h01, 8'h01, 1, 0, o(1, VO, 0, 8'h00, 1));
        add("t1_ack",     8'h01, 8'h01, 1, 1, o(0, 0,  1, 8'h00, 1));
        add("t1_done",    8'h00, 8'h01, 1, 0, o(0, 0,  0, 8'h00, 0));
        add("t1_quiet",   8'h00, 8'h01, 1, 0, o(0, 0,  0, 8'h00, 0));
        add("t2_comp",    8'h03, 8'h03, 1, 0, o(1, VC, 0, 8'h00, 1));
        add("t2_ack",     8'h03, 8'h03, 1, 1, o(0, 0,  1, 8'h01, 1));
        add("t2_gap",     8'h01, 8'h03, 1, 0, o(0, 0,  0, 8'h00, 0));
        add("t2_ovf",     8'h01, 8'h03, 1, 0, o(1, VO, 0, 8'h00, 1));
        add("t2_ack2",    8'h01, 8'h03, 1, 1, o(0, 0,  1, 8'h00, 1));
        add("t2_done",    8'h00, 8'h03, 1, 0, o(0, 0,  0, 8'h00, 0));
        add("idle_ack",   8'h00, 8'h03, 1, 1, o(0, 0,  0, 8'h00, 0));
        add("high_bits",  8'hFC, 8'hFC, 1, 0, o(0, 0,  0, 8'h00, 0));
        for (int i = 0; i < 20; i++)
            add("t3_nomask", 8'h01, 8'h02, 1, 0, o(0, 0, 0, 8'h00, 0));
        for (int i = 0; i < 5; i++)
            add("t3_noi",    8'h01, 8'h01, 0, 0, o(0, 0, 0, 8'h00, 0));
        add("t4_req",     8'h01, 8'h01, 1, 0, o(1, VO, 0, 8'h00, 1));
        add("t4_drop",    8'h01, 8'h01, 0, 0, o(0, 0,  0, 8'h00, 0));
        add("t4_rereq",   8'h01, 8'h01, 1, 0, o(1, VO, 0, 8'h00, 1));
        add("t5_ackdrop", 8'h01, 8'h01, 0, 1, o(0, 0,  1, 8'h00, 1));
        add("t5_done",    8'h00, 8'h01, 1, 0, o(0, 0,  0, 8'h00, 0));
        add("nora_ovf",   8'h01, 8'h03, 1, 0, o(1, VO, 0, 8'h00, 1));
        add("nora_hold",  8'h03, 8'h03, 1, 0, o(1, VO, 0, 8'h00, 1));
        add("nora_ack",   8'h03, 8'h03, 1, 1, o(0, 0,  1, 8'h02, 1));
        add("nora_gap",   8'h02, 8'h03, 1, 0, o(0, 0,  0, 8'h00, 0));
        add("nora_comp",  8'h02, 8'h03, 1, 0, o(1, VC, 0, 8'h00, 1));
        add("nora_ack2",  8'h02, 8'h03, 1, 1, o(0, 0,  1, 8'h00, 1));
        add("nora_done",  8'h00, 8'h03, 1, 0, o(0, 0,  0, 8'h00, 0));
        add("wd_flag",    8'h01, 8'h01, 1, 0, o(1, VO, 0, 8'h00, 1));
        add("wd_flag_off",8'h00, 8'h01, 1, 0, o(0, 0,  0, 8'h00, 0));
        add("pass_req",   8'hF1, 8'h01, 1, 0, o(1, VO, 0, 8'h00, 1));
        add("pass_ack",   8'hF1, 8'h01, 1, 1, o(0, 0,  1, 8'hF0, 1));
        add("pass_done",  8'hF0, 8'h01, 1, 0, o(0, 0,  0, 8'h00, 0));

        rst_n = 1'b0; TIFR_in = 8'h00; TIMSK_in = 8'h00; global_int_enable = 1'b0; irq_ack = 1'b0;
        repeat (2) @(posedge sysClock);
        #1;
        check("reset_state", o(0, 0, 0, 8'h00, 0), 1'b1);
        @(negedge sysClock);
        rst_n = 1'b1;

        foreach (tbl[i]) step(tbl[i]);

        // Asynchronous reset while a request is presented.
        begin
            vec_t v;
            v.name = "t6_req"; v.tifr = 8'h01; v.timsk = 8'h01; v.gie = 1; v.ack = 0;
            v.exp = o(1, VO, 0, 8'h00, 1);
            step(v);
            #2 rst_n = 1'b0;
            #1 check("t6_async_rst", o(0, 0, 0, 8'h00, 0), 1'b1);
            @(negedge sysClock);
            rst_n = 1'b1;
            v.name = "t6_rereq";
            step(v);
        end

        if (exp_q.size() != 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
